// File: rtl/commit_retire_unit.sv
// Two-wide in-order commit stage: retires scoreboard head entries, drives the
// register file write ports, reports exceptions and sequences serializing ops.
module commit_retire_unit #(
  parameter int unsigned INSTRET_W = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            commit_valid_i,
  input  logic [1:0][4:0]       commit_rd_i,
  input  logic [1:0][63:0]      commit_result_i,
  input  logic [1:0]            commit_fp_i,
  input  logic [1:0]            commit_ex_valid_i,
  input  logic [1:0][5:0]       commit_ex_cause_i,
  input  logic [1:0]            commit_serial_i,
  input  logic                  halt_i,
  input  logic                  flush_i,
  input  logic                  serial_done_i,
  input  logic [63:0]           serial_rdata_i,
  output logic [1:0]            commit_ack_o,
  output logic [1:0][4:0]       waddr_o,
  output logic [1:0][63:0]      wdata_o,
  output logic [1:0]            we_gpr_o,
  output logic [1:0]            we_fpr_o,
  output logic                  serial_req_o,
  output logic                  ex_valid_o,
  output logic [5:0]            ex_cause_o,
  output logic                  flush_o,
  output logic [INSTRET_W-1:0]  instret_o
);

  typedef enum logic [0:0] {
    IDLE,
    SERIAL_WAIT
  } state_e;

  state_e                 state_q, state_d;
  logic                   ex_valid_q, ex_valid_d;
  logic [5:0]             ex_cause_q, ex_cause_d;
  logic                   serial_req_q, serial_req_d;
  logic                   flush_q, flush_d;
  logic [INSTRET_W-1:0]   instret_q, instret_d;

  logic [1:0]             retire;
  logic [1:0]             retire_cnt;
  logic [5:0]             unused_cause_1;

  assign unused_cause_1 = commit_ex_cause_i[1];

  // Port 1 may only follow a normal port-0 retire; exceptions and serial ops
  // always retire alone from port 0.
  always_comb begin
    state_d      = state_q;
    ex_valid_d   = 1'b0;
    ex_cause_d   = 6'd0;
    serial_req_d = 1'b0;
    flush_d      = 1'b0;
    retire       = 2'b00;
    retire_cnt   = 2'd0;
    commit_ack_o = 2'b00;
    waddr_o      = commit_rd_i;
    wdata_o      = commit_result_i;

    if (rst_i) begin
      state_d = IDLE;
    end else if (flush_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!halt_i && commit_valid_i[0]) begin
            if (commit_ex_valid_i[0]) begin
              commit_ack_o[0] = 1'b1;
              ex_valid_d      = 1'b1;
              ex_cause_d      = commit_ex_cause_i[0];
            end else if (commit_serial_i[0]) begin
              serial_req_d = 1'b1;
              state_d      = SERIAL_WAIT;
            end else begin
              commit_ack_o[0] = 1'b1;
              retire[0]       = 1'b1;
              retire_cnt      = 2'd1;
              if (commit_valid_i[1] && !commit_ex_valid_i[1] && !commit_serial_i[1]) begin
                commit_ack_o[1] = 1'b1;
                retire[1]       = 1'b1;
                retire_cnt      = 2'd2;
              end
            end
          end
        end
        SERIAL_WAIT: begin
          // Completion is accepted even while halted so the CSR/fence op can drain.
          if (serial_done_i) begin
            commit_ack_o[0] = 1'b1;
            retire[0]       = 1'b1;
            retire_cnt      = 2'd1;
            wdata_o[0]      = serial_rdata_i;
            flush_d         = 1'b1;
            state_d         = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    for (int p = 0; p < 2; p++) begin
      we_gpr_o[p] = retire[p] && !commit_fp_i[p] && (commit_rd_i[p] != 5'd0);
      we_fpr_o[p] = retire[p] && commit_fp_i[p];
    end

    instret_d = instret_q + INSTRET_W'(retire_cnt);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      ex_valid_q   <= 1'b0;
      ex_cause_q   <= 6'd0;
      serial_req_q <= 1'b0;
      flush_q      <= 1'b0;
      instret_q    <= '0;
    end else begin
      state_q      <= state_d;
      ex_valid_q   <= ex_valid_d;
      ex_cause_q   <= ex_cause_d;
      serial_req_q <= serial_req_d;
      flush_q      <= flush_d;
      instret_q    <= instret_d;
    end
  end

  assign ex_valid_o   = ex_valid_q;
  assign ex_cause_o   = ex_cause_q;
  assign serial_req_o = serial_req_q;
  assign flush_o      = flush_q;
  assign instret_o    = instret_q;

endmodule

// File: tb/tb_commit_retire_unit.sv
// Directed bench for commit_retire_unit; runs the DUT with a 4-bit retire
// counter so that counter wrap is reachable in a short sequence.
module tb_commit_retire_unit;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [1:0]       commit_valid_i;
  logic [1:0][4:0]  commit_rd_i;
  logic [1:0][63:0] commit_result_i;
  logic [1:0]       commit_fp_i;
  logic [1:0]       commit_ex_valid_i;
  logic [1:0][5:0]  commit_ex_cause_i;
  logic [1:0]       commit_serial_i;
  logic             halt_i;
  logic             flush_i;
  logic             serial_done_i;
  logic [63:0]      serial_rdata_i;
  logic [1:0]       commit_ack_o;
  logic [1:0][4:0]  waddr_o;
  logic [1:0][63:0] wdata_o;
  logic [1:0]       we_gpr_o;
  logic [1:0]       we_fpr_o;
  logic             serial_req_o;
  logic             ex_valid_o;
  logic [5:0]       ex_cause_o;
  logic             flush_o;
  logic [3:0]       instret_o;

  int num_asserts = 0;
  int num_fails   = 0;

  commit_retire_unit #(.INSTRET_W(4)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .commit_valid_i    (commit_valid_i),
    .commit_rd_i       (commit_rd_i),
    .commit_result_i   (commit_result_i),
    .commit_fp_i       (commit_fp_i),
    .commit_ex_valid_i (commit_ex_valid_i),
    .commit_ex_cause_i (commit_ex_cause_i),
    .commit_serial_i   (commit_serial_i),
    .halt_i            (halt_i),
    .flush_i           (flush_i),
    .serial_done_i     (serial_done_i),
    .serial_rdata_i    (serial_rdata_i),
    .commit_ack_o      (commit_ack_o),
    .waddr_o           (waddr_o),
    .wdata_o           (wdata_o),
    .we_gpr_o          (we_gpr_o),
    .we_fpr_o          (we_fpr_o),
    .serial_req_o      (serial_req_o),
    .ex_valid_o        (ex_valid_o),
    .ex_cause_o        (ex_cause_o),
    .flush_o           (flush_o),
    .instret_o         (instret_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    num_asserts++;
    assert (observed === expected)
    else begin
      num_fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic clearInputs();
    commit_valid_i    = '0;
    commit_rd_i       = '0;
    commit_result_i   = '0;
    commit_fp_i       = '0;
    commit_ex_valid_i = '0;
    commit_ex_cause_i = '0;
    commit_serial_i   = '0;
    halt_i            = 1'b0;
    flush_i           = 1'b0;
    serial_done_i     = 1'b0;
    serial_rdata_i    = '0;
  endtask

  // Drives both head entries, then settles before combinational checks.
  task automatic applyStimulus(input logic [1:0] valid, input logic [4:0] rd0,
                               input logic [4:0] rd1, input logic [63:0] res0,
                               input logic [63:0] res1, input logic [1:0] fp,
                               input logic [1:0] exv, input logic [1:0] serial);
    commit_valid_i     = valid;
    commit_rd_i[0]     = rd0;
    commit_rd_i[1]     = rd1;
    commit_result_i[0] = res0;
    commit_result_i[1] = res1;
    commit_fp_i        = fp;
    commit_ex_valid_i  = exv;
    commit_serial_i    = serial;
    #1;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    clearInputs();
    rst_i = 1'b1;
    step();
    applyStimulus(2'b11, 5'd5, 5'd6, 64'hA, 64'hB, 2'b00, 2'b00, 2'b00);
    checkOutput("rst_ack", commit_ack_o, 2'b00);
    checkOutput("rst_we_gpr", we_gpr_o, 2'b00);
    step();
    checkOutput("rst_instret", instret_o, 4'd0);
    checkOutput("rst_ex_valid", ex_valid_o, 1'b0);
    checkOutput("rst_serial_req", serial_req_o, 1'b0);
    checkOutput("rst_flush", flush_o, 1'b0);
    rst_i = 1'b0;
    clearInputs();
    #1;

    // Dual GPR retire
    applyStimulus(2'b11, 5'd5, 5'd6, 64'hA, 64'hB, 2'b00, 2'b00, 2'b00);
    checkOutput("dual_ack", commit_ack_o, 2'b11);
    checkOutput("dual_we_gpr", we_gpr_o, 2'b11);
    checkOutput("dual_we_fpr", we_fpr_o, 2'b00);
    checkOutput("dual_waddr0", waddr_o[0], 5'd5);
    checkOutput("dual_waddr1", waddr_o[1], 5'd6);
    checkOutput("dual_wdata0", wdata_o[0], 64'hA);
    checkOutput("dual_wdata1", wdata_o[1], 64'hB);
    step();
    clearInputs();
    checkOutput("dual_instret", instret_o, 4'd2);

    // x0 suppressed, f0 written
    applyStimulus(2'b11, 5'd0, 5'd0, 64'h1, 64'h2, 2'b10, 2'b00, 2'b00);
    checkOutput("x0_ack", commit_ack_o, 2'b11);
    checkOutput("x0_we_gpr", we_gpr_o, 2'b00);
    checkOutput("x0_we_fpr", we_fpr_o, 2'b10);
    step();
    clearInputs();
    checkOutput("x0_instret", instret_o, 4'd4);

    // Port 0 exception
    applyStimulus(2'b11, 5'd7, 5'd8, 64'h3, 64'h4, 2'b00, 2'b01, 2'b00);
    commit_ex_cause_i[0] = 6'd2;
    #1;
    checkOutput("exc_ack", commit_ack_o, 2'b01);
    checkOutput("exc_we_gpr", we_gpr_o, 2'b00);
    checkOutput("exc_we_fpr", we_fpr_o, 2'b00);
    step();
    clearInputs();
    checkOutput("exc_ex_valid", ex_valid_o, 1'b1);
    checkOutput("exc_ex_cause", ex_cause_o, 6'd2);
    checkOutput("exc_instret", instret_o, 4'd4);
    step();
    checkOutput("exc_ex_valid_pulse", ex_valid_o, 1'b0);

    // Serial entry on port 1 blocks dual retire
    applyStimulus(2'b11, 5'd9, 5'd10, 64'h5, 64'h6, 2'b00, 2'b00, 2'b10);
    checkOutput("p1ser_ack", commit_ack_o, 2'b01);
    checkOutput("p1ser_we_gpr", we_gpr_o, 2'b01);
    step();
    clearInputs();
    checkOutput("p1ser_instret", instret_o, 4'd5);
    checkOutput("p1ser_serial_req", serial_req_o, 1'b0);

    // Exception wins over serial on the same entry
    applyStimulus(2'b01, 5'd11, 5'd0, 64'h7, 64'h0, 2'b00, 2'b01, 2'b01);
    commit_ex_cause_i[0] = 6'd7;
    #1;
    checkOutput("exser_ack", commit_ack_o, 2'b01);
    step();
    clearInputs();
    checkOutput("exser_ex_valid", ex_valid_o, 1'b1);
    checkOutput("exser_ex_cause", ex_cause_o, 6'd7);
    checkOutput("exser_serial_req", serial_req_o, 1'b0);
    checkOutput("exser_instret", instret_o, 4'd5);

    // Serializing op completing four cycles after the request
    applyStimulus(2'b01, 5'd3, 5'd0, 64'h0, 64'h0, 2'b00, 2'b00, 2'b01);
    checkOutput("ser_ack_idle", commit_ack_o, 2'b00);
    step();
    checkOutput("ser_req_pulse", serial_req_o, 1'b1);
    checkOutput("ser_wait_ack0", commit_ack_o, 2'b00);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("ser_req_low", serial_req_o, 1'b0);
      checkOutput("ser_wait_ack", commit_ack_o, 2'b00);
    end
    step();
    serial_done_i  = 1'b1;
    serial_rdata_i = 64'h55;
    #1;
    checkOutput("ser_done_ack", commit_ack_o, 2'b01);
    checkOutput("ser_done_wdata", wdata_o[0], 64'h55);
    checkOutput("ser_done_waddr", waddr_o[0], 5'd3);
    checkOutput("ser_done_we_gpr", we_gpr_o, 2'b01);
    step();
    clearInputs();
    checkOutput("ser_flush_pulse", flush_o, 1'b1);
    checkOutput("ser_instret", instret_o, 4'd6);
    step();
    checkOutput("ser_flush_low", flush_o, 1'b0);

    // serial_done in IDLE is ignored
    serial_done_i  = 1'b1;
    serial_rdata_i = 64'h99;
    applyStimulus(2'b01, 5'd4, 5'd0, 64'h44, 64'h0, 2'b00, 2'b00, 2'b00);
    checkOutput("idle_done_ack", commit_ack_o, 2'b01);
    checkOutput("idle_done_wdata", wdata_o[0], 64'h44);
    step();
    clearInputs();
    checkOutput("idle_done_flush", flush_o, 1'b0);
    checkOutput("idle_done_instret", instret_o, 4'd7);

    // Halt suppresses retirement
    halt_i = 1'b1;
    applyStimulus(2'b11, 5'd5, 5'd6, 64'hA, 64'hB, 2'b00, 2'b00, 2'b00);
    checkOutput("halt_ack", commit_ack_o, 2'b00);
    checkOutput("halt_we_gpr", we_gpr_o, 2'b00);
    step();
    clearInputs();
    checkOutput("halt_instret", instret_o, 4'd7);

    // Flush beats serial_done in SERIAL_WAIT
    applyStimulus(2'b01, 5'd3, 5'd0, 64'h0, 64'h0, 2'b00, 2'b00, 2'b01);
    step();
    serial_done_i  = 1'b1;
    serial_rdata_i = 64'h66;
    flush_i        = 1'b1;
    #1;
    checkOutput("flush_ack", commit_ack_o, 2'b00);
    checkOutput("flush_we_gpr", we_gpr_o, 2'b00);
    step();
    clearInputs();
    checkOutput("flush_no_flush_o", flush_o, 1'b0);
    applyStimulus(2'b01, 5'd2, 5'd0, 64'h22, 64'h0, 2'b00, 2'b00, 2'b00);
    checkOutput("flush_back_idle_ack", commit_ack_o, 2'b01);
    step();
    clearInputs();
    checkOutput("flush_instret", instret_o, 4'd8);

    // Halt does not block serial completion
    applyStimulus(2'b01, 5'd3, 5'd0, 64'h0, 64'h0, 2'b00, 2'b00, 2'b01);
    step();
    step();
    halt_i         = 1'b1;
    serial_done_i  = 1'b1;
    serial_rdata_i = 64'h77;
    #1;
    checkOutput("halt_done_ack", commit_ack_o, 2'b01);
    checkOutput("halt_done_wdata", wdata_o[0], 64'h77);
    step();
    clearInputs();
    checkOutput("halt_done_flush", flush_o, 1'b1);
    checkOutput("halt_done_instret", instret_o, 4'd9);

    // Reset during SERIAL_WAIT abandons the operation
    applyStimulus(2'b01, 5'd3, 5'd0, 64'h0, 64'h0, 2'b00, 2'b00, 2'b01);
    step();
    checkOutput("rstsw_req", serial_req_o, 1'b1);
    rst_i          = 1'b1;
    serial_done_i  = 1'b1;
    serial_rdata_i = 64'h88;
    #1;
    checkOutput("rstsw_ack", commit_ack_o, 2'b00);
    checkOutput("rstsw_we_gpr", we_gpr_o, 2'b00);
    step();
    checkOutput("rstsw_serial_req", serial_req_o, 1'b0);
    checkOutput("rstsw_flush", flush_o, 1'b0);
    checkOutput("rstsw_ex_valid", ex_valid_o, 1'b0);
    checkOutput("rstsw_instret", instret_o, 4'd0);
    rst_i = 1'b0;
    clearInputs();
    applyStimulus(2'b01, 5'd1, 5'd0, 64'h11, 64'h0, 2'b00, 2'b00, 2'b00);
    checkOutput("rstsw_idle_ack", commit_ack_o, 2'b01);
    step();
    clearInputs();
    checkOutput("rstsw_instret_after", instret_o, 4'd1);

    // Counter wrap: single retires up to 15, then a dual retire
    for (int i = 0; i < 14; i++) begin
      applyStimulus(2'b01, 5'd1, 5'd0, 64'h1, 64'h0, 2'b00, 2'b00, 2'b00);
      step();
    end
    clearInputs();
    #1;
    checkOutput("wrap_preset", instret_o, 4'd15);
    applyStimulus(2'b11, 5'd5, 5'd6, 64'hA, 64'hB, 2'b00, 2'b00, 2'b00);
    step();
    clearInputs();
    checkOutput("wrap_instret", instret_o, 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", num_asserts, num_fails);
    $finish;
  end

endmodule

// File: doc/commit_retire_unit.md
COMMIT_RETIRE_UNIT -- requirements
Module: commit_retire_unit

Interface
REQ-001 Parameter: INSTRET_W, default 64, width of the retired-instruction counter.
REQ-002 clk_i  input  1  single clock, all state updates on rising edge.
REQ-003 rst_i  input  1  reset; synchronous and active-high.
REQ-004 commit_valid_i  input  2  scoreboard head entries valid; bit 0 is oldest.
REQ-005 commit_rd_i  input  2x5  destination register per port.
REQ-006 commit_result_i  input  2x64  writeback result per port.
REQ-007 commit_fp_i  input  2  destination is FP register file.
REQ-008 commit_ex_valid_i  input  2  entry carries exception.
REQ-009 commit_ex_cause_i  input  2x6  exception cause per port.
REQ-010 commit_serial_i  input  2  entry is CSR/fence; needs external completion.
REQ-011 halt_i  input  1  stall retirement (debug/WFI).
REQ-012 flush_i  input  1  pipeline flush.
REQ-013 serial_done_i  input  1  serializing operation complete.
REQ-014 serial_rdata_i  input  64  result of serializing operation.
REQ-015 commit_ack_o  output  2  per-port retire acknowledge to scoreboard.
REQ-016 waddr_o  output  2x5; wdata_o  output  2x64; we_gpr_o  output  2; we_fpr_o  output  2 -- register file write ports.
REQ-017 serial_req_o  output  1  start serializing operation (one-cycle pulse).
REQ-018 ex_valid_o  output  1; ex_cause_o  output  6 -- registered exception report.
REQ-019 flush_o  output  1  request pipeline flush after serializing retire (one-cycle pulse).
REQ-020 instret_o  output  INSTRET_W  count of retired non-excepting instructions.

Function
REQ-021 commit_ack_o, waddr_o, wdata_o, we_gpr_o, we_fpr_o SHALL be combinational from inputs and FSM state; ack and write of a port SHALL occur in the same cycle.
REQ-022 FSM states: IDLE, SERIAL_WAIT.
REQ-023 In IDLE with halt_i=0, flush_i=0, port 0 valid, no exception, not serial: ack port 0; write result to rd (GPR if commit_fp_i=0, FPR otherwise).
REQ-024 Port 1 SHALL be acked in the same cycle only if port 0 is acked as a normal (non-excepting, non-serial) retire and port 1 is valid, non-excepting and non-serial.
REQ-025 GPR write to rd=0 SHALL be suppressed (we_gpr_o=0) while the ack still occurs; FPR writes to f0 SHALL proceed.
REQ-026 Port 0 valid with exception (IDLE, no halt/flush): ack port 0, no register write, port 1 not acked; next cycle ex_valid_o=1 for one cycle with ex_cause_o = port-0 cause.
REQ-027 Exception SHALL take priority over serial on the same entry.
REQ-028 Port 0 valid, serial, no exception, in IDLE: no ack; serial_req_o=1 next cycle for one cycle; state -> SERIAL_WAIT.
REQ-029 In SERIAL_WAIT: no ack until serial_done_i=1; on serial_done_i: ack port 0, write serial_rdata_i to rd (REQ-025 applies), state -> IDLE, flush_o=1 next cycle for one cycle; port 1 not acked.
REQ-030 serial_done_i in IDLE SHALL be ignored.
REQ-031 halt_i=1 SHALL suppress all acks and writes and hold FSM state; it SHALL NOT block serial_done_i completion in SERIAL_WAIT.
REQ-032 flush_i=1 SHALL suppress all acks, writes and new exception/serial reports, and return FSM to IDLE; flush_i wins over simultaneous serial_done_i.
REQ-033 instret_o SHALL add the number of non-excepting acks each cycle (0,1,2), wrapping modulo 2^INSTRET_W.

Reset
REQ-034 On rst_i=1 at a clock edge: state IDLE, instret_o=0, ex_valid_o=0, ex_cause_o=0, serial_req_o=0, flush_o=0.
REQ-035 While rst_i=1: commit_ack_o=0, we_gpr_o=0, we_fpr_o=0; reset during SERIAL_WAIT abandons the operation without ack.

Verification
REQ-036 Both ports valid normal, rd=5/rd=6 GPR, results 0xA/0xB -> ack=2'b11, we_gpr=2'b11, wdata 0xA/0xB, instret +2 next cycle.
REQ-037 Port 0 rd=0 GPR, port 1 FPR rd=0 -> ack=2'b11, we_gpr=2'b00, we_fpr=2'b10, instret +2.
REQ-038 Port 0 exception cause 2, port 1 normal -> ack=2'b01, no writes, next cycle ex_valid_o=1 ex_cause_o=2, instret unchanged.
REQ-039 Port 0 serial rd=3; serial_done_i asserted 4 cycles after serial_req_o with serial_rdata_i=0x55 -> serial_req_o one pulse, no ack while waiting, ack=2'b01 with wdata 0x55 on done cycle, flush_o pulse next cycle.
REQ-040 flush_i concurrent with serial_done_i in SERIAL_WAIT -> ack=0, no flush_o, state IDLE; rst_i mid-SERIAL_WAIT -> all outputs at reset values.
REQ-041 instret_o preset near wrap (INSTRET_W=4, at 15) plus two-port retire -> instret_o=1.
